// File: rtl/rtc_bus_reader.sv
`default_nettype none
// ============================================================================
//  Module   : rtc_bus_reader
//  Purpose  : Sweeps the nine RTC time/date/timer registers over the chip's
//             multiplexed address/data bus and streams each byte into the
//             staging bank of the double-buffered register memory.
//  Revision : 1.0  initial release
// ============================================================================
module rtc_bus_reader #(
    parameter int PHASE_CYC = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       leer,
    input  logic       actready,
    input  logic [7:0] ad_in,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic       a_d,
    output logic [3:0] ADD1,
    output logic [7:0] DAT1,
    output logic       w1,
    output logic       whileT,
    output logic       busy
);

    // Last register index of a sweep, last count of a bus phase, and the
    // memory index the write port parks on while idle (never shadow-copied).
    localparam logic [3:0] c_LAST_IDX   = 4'd8;
    localparam logic [3:0] c_PHASE_LAST = 4'(PHASE_CYC - 1);
    localparam logic [3:0] c_IDLE_ADD   = 4'd15;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_OPEN  = 3'd1,
        S_ADDR  = 3'd2,
        S_GAP   = 3'd3,
        S_DATA  = 3'd4,
        S_STORE = 3'd5,
        S_CLOSE = 3'd6,
        S_WAIT  = 3'd7
    } state_t;

    state_t     r_state;
    state_t     w_state_d;
    logic [3:0] r_idx;
    logic [3:0] w_idx_d;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_d;
    logic       r_pend;
    logic [7:0] r_cap;

    // Registered copies of every output so the bus and memory ports are
    // glitch-free; each is decoded from the next state so it lines up with
    // the state it belongs to.
    logic [7:0] r_ad_out, w_ad_out_d;
    logic       r_ad_oe,  w_ad_oe_d;
    logic       r_cs_n,   w_cs_n_d;
    logic       r_rd_n,   w_rd_n_d;
    logic       r_wr_n,   w_wr_n_d;
    logic       r_a_d,    w_a_d_d;
    logic       r_while,  w_while_d;
    logic       r_busy,   w_busy_d;
    logic [3:0] r_add1;
    logic [7:0] r_dat1;
    logic       r_w1;

    // Chip register address for sweep slot idx: clock block at 0x21..0x26,
    // timer block at 0x41..0x43.
    function automatic logic [7:0] f_chip_addr(input logic [3:0] idx);
        logic [7:0] a;
        case (idx)
            4'd0:    a = 8'h21;
            4'd1:    a = 8'h22;
            4'd2:    a = 8'h23;
            4'd3:    a = 8'h24;
            4'd4:    a = 8'h25;
            4'd5:    a = 8'h26;
            4'd6:    a = 8'h41;
            4'd7:    a = 8'h42;
            4'd8:    a = 8'h43;
            default: a = 8'h00;
        endcase
        return a;
    endfunction

    // Memory slot for sweep slot idx: timer registers skip slots 6 and 7.
    function automatic logic [3:0] f_mem_index(input logic [3:0] idx);
        logic [3:0] m;
        case (idx)
            4'd0:    m = 4'd0;
            4'd1:    m = 4'd1;
            4'd2:    m = 4'd2;
            4'd3:    m = 4'd3;
            4'd4:    m = 4'd4;
            4'd5:    m = 4'd5;
            4'd6:    m = 4'd8;
            4'd7:    m = 4'd9;
            4'd8:    m = 4'd10;
            default: m = c_IDLE_ADD;
        endcase
        return m;
    endfunction

    // Next-state, slot index and phase counter, then output decode of the
    // next state.
    always_comb begin
        w_state_d = r_state;
        w_idx_d   = r_idx;
        w_cnt_d   = 4'd0;

        case (r_state)
            S_IDLE: begin
                if (r_pend || leer) begin
                    w_state_d = S_OPEN;
                end
            end
            S_OPEN: begin
                w_idx_d   = 4'd0;
                w_state_d = S_ADDR;
            end
            S_ADDR: begin
                if (r_cnt == c_PHASE_LAST) begin
                    w_state_d = S_GAP;
                end else begin
                    w_cnt_d = r_cnt + 4'd1;
                end
            end
            S_GAP: begin
                if (r_cnt == c_PHASE_LAST) begin
                    w_state_d = S_DATA;
                end else begin
                    w_cnt_d = r_cnt + 4'd1;
                end
            end
            S_DATA: begin
                if (r_cnt == c_PHASE_LAST) begin
                    w_state_d = S_STORE;
                end else begin
                    w_cnt_d = r_cnt + 4'd1;
                end
            end
            S_STORE: begin
                if (r_idx == c_LAST_IDX) begin
                    w_state_d = S_CLOSE;
                end else begin
                    w_idx_d   = r_idx + 4'd1;
                    w_state_d = S_ADDR;
                end
            end
            S_CLOSE: begin
                w_state_d = S_WAIT;
            end
            S_WAIT: begin
                if (actready) begin
                    w_state_d = S_IDLE;
                end
            end
            default: begin
                w_state_d = S_IDLE;
                w_idx_d   = 4'd0;
            end
        endcase

        // Bus idle unless the next state is one of the three bus phases.
        w_ad_out_d = 8'h00;
        w_ad_oe_d  = 1'b0;
        w_cs_n_d   = 1'b1;
        w_rd_n_d   = 1'b1;
        w_wr_n_d   = 1'b1;
        w_a_d_d    = 1'b1;

        case (w_state_d)
            S_ADDR: begin
                w_cs_n_d   = 1'b0;
                w_wr_n_d   = 1'b0;
                w_a_d_d    = 1'b0;
                w_ad_oe_d  = 1'b1;
                w_ad_out_d = f_chip_addr(w_idx_d);
            end
            S_DATA: begin
                w_cs_n_d = 1'b0;
                w_rd_n_d = 1'b0;
            end
            default: begin
            end
        endcase

        // The write window spans every bus phase plus CLOSE, so the final
        // w1 pulse (issued in CLOSE) still lands inside it.
        w_while_d = (w_state_d == S_ADDR)  || (w_state_d == S_GAP)   ||
                    (w_state_d == S_DATA)  || (w_state_d == S_STORE) ||
                    (w_state_d == S_CLOSE);
        w_busy_d  = w_while_d || (w_state_d == S_WAIT);
    end

    // State, index and phase counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_idx   <= 4'd0;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_d;
            r_idx   <= w_idx_d;
            r_cnt   <= w_cnt_d;
        end
    end

    // Pending request: entering OPEN consumes it, any later leer re-arms it
    // so a request made mid-sweep is serviced once afterwards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pend <= 1'b0;
        end else if ((w_state_d == S_OPEN) && (r_state != S_OPEN)) begin
            r_pend <= 1'b0;
        end else if (leer) begin
            r_pend <= 1'b1;
        end
    end

    // Capture the chip's byte on the edge that ends the data phase.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cap <= 8'h00;
        end else if ((r_state == S_DATA) && (r_cnt == c_PHASE_LAST)) begin
            r_cap <= ad_in;
        end
    end

    // Memory write port: STORE loads the index/data pair and raises w1 for
    // exactly one cycle; the pair then holds until the next write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_add1 <= c_IDLE_ADD;
            r_dat1 <= 8'h00;
            r_w1   <= 1'b0;
        end else begin
            r_w1 <= (r_state == S_STORE);
            if (r_state == S_STORE) begin
                r_add1 <= f_mem_index(r_idx);
                r_dat1 <= r_cap;
            end
        end
    end

    // Bus control and handshake flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ad_out <= 8'h00;
            r_ad_oe  <= 1'b0;
            r_cs_n   <= 1'b1;
            r_rd_n   <= 1'b1;
            r_wr_n   <= 1'b1;
            r_a_d    <= 1'b1;
            r_while  <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_ad_out <= w_ad_out_d;
            r_ad_oe  <= w_ad_oe_d;
            r_cs_n   <= w_cs_n_d;
            r_rd_n   <= w_rd_n_d;
            r_wr_n   <= w_wr_n_d;
            r_a_d    <= w_a_d_d;
            r_while  <= w_while_d;
            r_busy   <= w_busy_d;
        end
    end

    assign ad_out = r_ad_out;
    assign ad_oe  = r_ad_oe;
    assign cs_n   = r_cs_n;
    assign rd_n   = r_rd_n;
    assign wr_n   = r_wr_n;
    assign a_d    = r_a_d;
    assign ADD1   = r_add1;
    assign DAT1   = r_dat1;
    assign w1     = r_w1;
    assign whileT = r_while;
    assign busy   = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_rtc_bus_reader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_rtc_bus_reader
//  Purpose  : Directed self-checking bench for rtc_bus_reader with a small
//             RTC chip model; one instance at PHASE_CYC=4, one at 2.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rtc_bus_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       leer, actready, leer2, actready2;
    logic [7:0] ad_in, ad_out, ad_in2, ad_out2;
    logic       ad_oe, cs_n, rd_n, wr_n, a_d, w1, whileT, busy;
    logic       ad_oe2, cs_n2, rd_n2, wr_n2, a_d2, w1_2, whileT2, busy2;
    logic [3:0] ADD1, ADD1_2;
    logic [7:0] DAT1, DAT1_2;

    rtc_bus_reader #(.PHASE_CYC(4)) dut (
        .clk(clk), .reset(reset), .leer(leer), .actready(actready),
        .ad_in(ad_in), .ad_out(ad_out), .ad_oe(ad_oe), .cs_n(cs_n),
        .rd_n(rd_n), .wr_n(wr_n), .a_d(a_d), .ADD1(ADD1), .DAT1(DAT1),
        .w1(w1), .whileT(whileT), .busy(busy)
    );

    rtc_bus_reader #(.PHASE_CYC(2)) dut2 (
        .clk(clk), .reset(reset), .leer(leer2), .actready(actready2),
        .ad_in(ad_in2), .ad_out(ad_out2), .ad_oe(ad_oe2), .cs_n(cs_n2),
        .rd_n(rd_n2), .wr_n(wr_n2), .a_d(a_d2), .ADD1(ADD1_2), .DAT1(DAT1_2),
        .w1(w1_2), .whileT(whileT2), .busy(busy2)
    );

    // Expected sweep: chip addresses, memory slots and the bytes the model returns.
    logic [7:0] addr_tab [0:8] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43};
    logic [3:0] exp_add  [0:8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd8, 4'd9, 4'd10};
    logic [7:0] exp_dat  [0:8] = '{8'h59, 8'h30, 8'h12, 8'h15, 8'h09, 8'h16, 8'h05, 8'h04, 8'h03};

    function automatic logic [7:0] rtc_data(input logic [7:0] a);
        case (a)
            8'h21:   return 8'h59;
            8'h22:   return 8'h30;
            8'h23:   return 8'h12;
            8'h24:   return 8'h15;
            8'h25:   return 8'h09;
            8'h26:   return 8'h16;
            8'h41:   return 8'h05;
            8'h42:   return 8'h04;
            8'h43:   return 8'h03;
            default: return 8'hEE;
        endcase
    endfunction

    // RTC chip model: latches the address phase, drives data while read.
    logic [7:0] rtc_addr1 = 8'h00, rtc_addr2 = 8'h00;
    always @(posedge clk) begin
        if (!cs_n && !a_d && !wr_n)     rtc_addr1 <= ad_out;
        if (!cs_n2 && !a_d2 && !wr_n2)  rtc_addr2 <= ad_out2;
    end
    assign ad_in  = (!cs_n  && !rd_n)  ? rtc_data(rtc_addr1) : 8'hFF;
    assign ad_in2 = (!cs_n2 && !rd_n2) ? rtc_data(rtc_addr2) : 8'hFF;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Cycle monitor for the PHASE_CYC=4 instance.
    int cyc = 0, w1_n = 0, wt_n = 0, addr_bad = 0, conflict_n = 0, idle_viol = 0;
    int run = 0, ak = 0;
    logic [3:0] w1_add [0:63];
    logic [7:0] w1_dat [0:63];
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            run = 0;
            ak  = 0;
        end else begin
            if (!cs_n && !a_d) begin
                run++;
                if (wr_n !== 1'b0 || ad_oe !== 1'b1 || ad_out !== addr_tab[ak]) addr_bad++;
            end else if (run != 0) begin
                if (run != 4) addr_bad++;
                run = 0;
                ak  = (ak + 1) % 9;
            end
            if (ad_oe && !rd_n) conflict_n++;
            if (w1) begin
                if (w1_n < 64) begin
                    w1_add[w1_n] = ADD1;
                    w1_dat[w1_n] = DAT1;
                end
                if (!whileT) addr_bad++;
                w1_n++;
            end
            if (whileT) wt_n++;
            if (!cs_n || ad_oe || whileT || busy || w1) idle_viol++;
        end
    end

    // Cycle monitor for the PHASE_CYC=2 instance.
    int w1_n2 = 0, wt_n2 = 0;
    int w1_cyc2 [0:15];
    logic [3:0] w1_add2 [0:15];
    logic [7:0] w1_dat2 [0:15];
    always @(negedge clk) begin
        if (!reset) begin
            if (w1_2) begin
                if (w1_n2 < 16) begin
                    w1_cyc2[w1_n2] = cyc;
                    w1_add2[w1_n2] = ADD1_2;
                    w1_dat2[w1_n2] = DAT1_2;
                end
                w1_n2++;
            end
            if (whileT2) wt_n2++;
        end
    end

    task automatic pulse_leer();
        @(posedge clk); #1 leer = 1'b1;
        @(posedge clk); #1 leer = 1'b0;
    endtask

    task automatic accept_actready();
        @(posedge clk); #1 actready = 1'b1;
        @(posedge clk); #1 actready = 1'b0;
    endtask

    // Bounded wait for the PHASE_CYC=4 instance to reach WAIT.
    task automatic wait_for_wait(input string nm);
        int n;
        n = 0;
        while (!(busy && !whileT) && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        check({nm, "_reached_wait"}, 32'(busy && !whileT), 32'd1);
    endtask

    task automatic check_pairs(input string nm, input int base);
        for (int j = 0; j < 9; j++) begin
            check($sformatf("%s_add%0d", nm, j), 32'(w1_add[base + j]), 32'(exp_add[j]));
            check($sformatf("%s_dat%0d", nm, j), 32'(w1_dat[base + j]), 32'(exp_dat[j]));
        end
    endtask

    task automatic full_sweep(input string nm, input bit timing);
        int b_w, b_wt, b_bad, b_cf;
        b_w = w1_n; b_wt = wt_n; b_bad = addr_bad; b_cf = conflict_n;
        pulse_leer();
        if (timing) begin
            check({nm, "_open_whileT"}, 32'(whileT), 32'd0);
            @(posedge clk); #1;
            check({nm, "_whileT_rise"}, 32'(whileT), 32'd1);
            check({nm, "_busy_rise"}, 32'(busy), 32'd1);
        end
        wait_for_wait(nm);
        check({nm, "_w1_count"}, 32'(w1_n - b_w), 32'd9);
        check_pairs(nm, b_w);
        check({nm, "_whileT_cycles"}, 32'(wt_n - b_wt), 32'd118);
        check({nm, "_addr_phase"}, 32'(addr_bad - b_bad), 32'd0);
        check({nm, "_oe_rd_conflict"}, 32'(conflict_n - b_cf), 32'd0);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int b_w, b_wt, v0, n;
        reset = 1'b1; leer = 1'b0; actready = 1'b0; leer2 = 1'b0; actready2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cs_n",   32'(cs_n),   32'd1);
        check("rst_rd_n",   32'(rd_n),   32'd1);
        check("rst_wr_n",   32'(wr_n),   32'd1);
        check("rst_a_d",    32'(a_d),    32'd1);
        check("rst_ad_oe",  32'(ad_oe),  32'd0);
        check("rst_ad_out", 32'(ad_out), 32'd0);
        check("rst_w1",     32'(w1),     32'd0);
        check("rst_whileT", 32'(whileT), 32'd0);
        check("rst_busy",   32'(busy),   32'd0);
        check("rst_ADD1",   32'(ADD1),   32'd15);
        check("rst_DAT1",   32'(DAT1),   32'd0);
        @(negedge clk) reset = 1'b0;

        v0 = idle_viol;
        repeat (200) @(posedge clk);
        #1 check("idle_after_reset", 32'(idle_viol - v0), 32'd0);

        // Single sweep with launch timing, then a long WAIT.
        full_sweep("sweep1", 1'b1);
        b_w = w1_n;
        repeat (500) @(posedge clk);
        #1;
        check("wait_hold_busy",   32'(busy),       32'd1);
        check("wait_hold_whileT", 32'(whileT),     32'd0);
        check("wait_hold_no_w1",  32'(w1_n - b_w), 32'd0);
        accept_actready();
        check("busy_drop", 32'(busy), 32'd0);

        // Two requests and a stray actready during a sweep.
        b_w = w1_n;
        pulse_leer();
        repeat (20) @(posedge clk);
        #1 leer = 1'b1;
        @(posedge clk); #1 leer = 1'b0;
        repeat (10) @(posedge clk);
        #1 actready = 1'b1;
        repeat (5) @(posedge clk);
        #1 actready = 1'b0;
        repeat (20) @(posedge clk);
        #1 leer = 1'b1;
        @(posedge clk); #1 leer = 1'b0;
        wait_for_wait("dbl_a");
        check("dbl_a_w1_count", 32'(w1_n - b_w), 32'd9);
        repeat (3) @(posedge clk);
        accept_actready();
        check("dbl_accept_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        check("dbl_open_whileT", 32'(whileT), 32'd0);
        @(posedge clk); #1;
        check("dbl_resweep_start", 32'(whileT), 32'd1);
        wait_for_wait("dbl_b");
        check("dbl_total_w1", 32'(w1_n - b_w), 32'd18);
        check_pairs("dbl_b", b_w + 9);
        accept_actready();
        v0 = idle_viol;
        repeat (100) @(posedge clk);
        #1 check("dbl_no_third_sweep", 32'(idle_viol - v0), 32'd0);

        // Short-phase instance.
        b_w = w1_n2; b_wt = wt_n2;
        @(posedge clk); #1 leer2 = 1'b1;
        @(posedge clk); #1 leer2 = 1'b0;
        n = 0;
        while (!(busy2 && !whileT2) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check("p2_reached_wait", 32'(busy2 && !whileT2), 32'd1);
        check("p2_w1_count", 32'(w1_n2 - b_w), 32'd9);
        check("p2_whileT_cycles", 32'(wt_n2 - b_wt), 32'd64);
        for (int j = 1; j < 9; j++)
            check($sformatf("p2_period%0d", j), 32'(w1_cyc2[b_w + j] - w1_cyc2[b_w + j - 1]), 32'd7);
        for (int j = 0; j < 9; j++) begin
            check($sformatf("p2_add%0d", j), 32'(w1_add2[b_w + j]), 32'(exp_add[j]));
            check($sformatf("p2_dat%0d", j), 32'(w1_dat2[b_w + j]), 32'(exp_dat[j]));
        end

        // Reset in the middle of the address phase of register 3.
        b_w = w1_n;
        pulse_leer();
        n = 0;
        while (!((w1_n - b_w) == 3 && !cs_n && !a_d) && n < 400) begin
            @(posedge clk); #2;
            n++;
        end
        check("mid_in_addr3", 32'(ad_out), 32'h24);
        #1 reset = 1'b1;
        #1;
        check("mid_rst_cs_n",   32'(cs_n),   32'd1);
        check("mid_rst_ad_oe",  32'(ad_oe),  32'd0);
        check("mid_rst_wr_n",   32'(wr_n),   32'd1);
        check("mid_rst_whileT", 32'(whileT), 32'd0);
        check("mid_rst_ADD1",   32'(ADD1),   32'd15);
        check("mid_rst_busy",   32'(busy),   32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        b_w = w1_n;
        v0  = idle_viol;
        repeat (200) @(posedge clk);
        #1;
        check("post_rst_idle", 32'(idle_viol - v0), 32'd0);
        check("post_rst_no_w1", 32'(w1_n - b_w), 32'd0);
        full_sweep("post_rst", 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
